// File: rtl/parity_scan_ctrl.sv
// Serial nibble-parity scanner: captures a 4*NIB-bit word on start, shifts it out LSB first and
// publishes per-nibble parity flags plus E/O glyphs. Optional whole-word total under PARITY_TOTAL_EN.
module parity_scan_ctrl #(
    parameter int          NIB       = 4,
    parameter logic [6:0]  SEG_EVEN  = 7'b0000110,
    parameter logic [6:0]  SEG_ODD   = 7'b1000000,
    parameter logic [6:0]  SEG_BLANK = 7'b1111111
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [4*NIB-1:0]   data_in,
    output logic               busy,
    output logic               done,
    output logic [NIB-1:0]     par_out,
    output logic [7*NIB-1:0]   hex_out,
`ifdef PARITY_TOTAL_EN
    output logic               par_total,
    output logic [6:0]         hex_total,
`endif
    output logic               o_dbg_state
);

    localparam int W  = 4 * NIB;
    localparam int CW = $clog2(W);

    // Handshake: start is taken on any edge where the FSM is IDLE (including the done cycle);
    // busy is high for exactly W cycles afterwards, then done pulses for one cycle with results.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_scan_last;

    logic [W-1:0]      r_sreg;
    logic [CW-1:0]     r_cnt;
    logic              r_acc;
    logic [NIB-1:0]    r_slot;
    logic [NIB-1:0]    r_par;
    logic [7*NIB-1:0]  r_hex;
    logic              r_done;

    logic              w_bit;
    logic              w_nib_par;
    logic              w_nib_end;
    logic [CW-1:0]     w_nib_idx;
    logic [NIB-1:0]    w_slot_next;
    logic [7*NIB-1:0]  w_hex_next;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_scan_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_cnt == CW'(W - 1)) begin
                    w_scan_last  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bit-serial parity datapath
    // ------------------------------------------------------------------
    assign w_bit     = r_sreg[0];
    assign w_nib_par = r_acc ^ w_bit;
    assign w_nib_end = (r_cnt[1:0] == 2'b11);
    assign w_nib_idx = r_cnt >> 2;

    // Slot view including the nibble that closes on this edge, so the final
    // nibble is part of the published result on the completion edge.
    always_comb begin
        w_slot_next = r_slot;
        for (int k = 0; k < NIB; k++) begin
            if (w_nib_end && (w_nib_idx == CW'(k))) begin
                w_slot_next[k] = w_nib_par;
            end
        end
    end

    always_comb begin
        w_hex_next = '0;
        for (int k = 0; k < NIB; k++) begin
            w_hex_next[7*k +: 7] = w_slot_next[k] ? SEG_ODD : SEG_EVEN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_acc  <= 1'b0;
            r_slot <= '0;
            r_par  <= '0;
            r_hex  <= {NIB{SEG_BLANK}};
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_sreg <= data_in;
                r_cnt  <= '0;
                r_acc  <= 1'b0;
                r_slot <= '0;
            end else if (r_state == S_SCAN) begin
                r_sreg <= r_sreg >> 1;
                r_cnt  <= r_cnt + CW'(1);
                r_acc  <= w_nib_end ? 1'b0 : w_nib_par;
                r_slot <= w_slot_next;
                if (w_scan_last) begin
                    r_cnt  <= '0;
                    r_par  <= w_slot_next;
                    r_hex  <= w_hex_next;
                    r_done <= 1'b1;
                end
            end
        end
    end

`ifdef PARITY_TOTAL_EN
    logic       r_ptot;
    logic [6:0] r_htot;
    logic       w_total;

    assign w_total = ^w_slot_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptot <= 1'b0;
            r_htot <= SEG_BLANK;
        end else if ((r_state == S_SCAN) && w_scan_last) begin
            r_ptot <= w_total;
            r_htot <= w_total ? SEG_ODD : SEG_EVEN;
        end
    end

    assign par_total = r_ptot;
    assign hex_total = r_htot;
`endif

    assign busy        = (r_state == S_SCAN);
    assign done        = r_done;
    assign par_out     = r_par;
    assign hex_out     = r_hex;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// Scoreboard bench for parity_scan_ctrl: model pushes expected parity at start acceptance,
// monitor pops on done and checks timing, hold behaviour and reset values.
module tb_parity_scan_ctrl;
  localparam int NIB = 4;
  localparam int W = 4 * NIB;
  localparam logic [6:0] SEG_EVEN = 7'b0000110;
  localparam logic [6:0] SEG_ODD = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // clock / reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic busy;
  logic done;
  logic [NIB-1:0] par_out;
  logic [7*NIB-1:0] hex_out;
  logic dbg_state;
`ifdef PARITY_TOTAL_EN
  logic par_total;
  logic [6:0] hex_total;
`endif

  always #5 clk = ~clk;

  parity_scan_ctrl #(
    .NIB(NIB), .SEG_EVEN(SEG_EVEN), .SEG_ODD(SEG_ODD), .SEG_BLANK(SEG_BLANK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .data_in(data_in),
    .busy(busy),
    .done(done),
    .par_out(par_out),
    .hex_out(hex_out),
`ifdef PARITY_TOTAL_EN
    .par_total(par_total),
    .hex_total(hex_total),
`endif
    .o_dbg_state(dbg_state)
  );

  // scoreboard state
  logic [NIB-1:0] exp_q[$];
  int due_q[$];
  int cyc = 0;
  int m_rem = 0;
  int rst_gen = 0;
  bit m_live = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [NIB-1:0] ref_par(input logic [W-1:0] d);
    logic [NIB-1:0] r;
    logic [3:0] nib;
    r = '0;
    for (int k = 0; k < NIB; k++) begin
      nib = d[4*k +: 4];
      r[k] = (($countones(nib) % 2) == 1);
    end
    return r;
  endfunction

  function automatic logic [7*NIB-1:0] glyphs(input logic [NIB-1:0] p);
    logic [7*NIB-1:0] g;
    for (int k = 0; k < NIB; k++) g[7*k +: 7] = p[k] ? SEG_ODD : SEG_EVEN;
    return g;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: sees every sampled edge, decides acceptance from scan length alone
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_rem = 0;
      rst_gen++;
      m_live = 1'b1;
    end else if (m_rem == 0) begin
      if (start) begin
        m_rem = W;
        exp_q.push_back(ref_par(data_in));
        due_q.push_back(cyc + W);
      end
    end else begin
      m_rem--;
    end
  end

  // monitor
  logic [NIB-1:0] hold_par = '0;
  bit hold_blank = 1'b1;
  int seen_gen = 0;
  always @(negedge clk) begin
    if (m_live) begin
      if (seen_gen != rst_gen) begin
        seen_gen = rst_gen;
        exp_q.delete();
        due_q.delete();
        hold_par = '0;
        hold_blank = 1'b1;
      end
      check("busy", 64'(busy), 64'(m_rem > 0));
      check("dbg_state", 64'(dbg_state), 64'(m_rem > 0));
      if (done) begin
        if (due_q.size() == 0) begin
          check("spurious_done", 64'(done), 64'(1'b0));
        end else begin
          check("done_cycle", 64'(cyc), 64'(due_q.pop_front()));
          hold_par = exp_q.pop_front();
          hold_blank = 1'b0;
        end
      end else if (due_q.size() > 0 && cyc >= due_q[0]) begin
        check("done_missing", 64'(done), 64'(1'b1));
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end
      check("par_out", 64'(par_out), 64'(hold_par));
      check("hex_out", 64'(hex_out), hold_blank ? 64'({NIB{SEG_BLANK}}) : 64'(glyphs(hold_par)));
`ifdef PARITY_TOTAL_EN
      check("par_total", 64'(par_total), 64'(^hold_par));
      check("hex_total", 64'(hex_total),
            hold_blank ? 64'(SEG_BLANK) : ((^hold_par) ? 64'(SEG_ODD) : 64'(SEG_EVEN)));
`endif
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic start_pulse(input logic [W-1:0] d);
    start = 1'b1;
    data_in = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic reset_pulse(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((due_q.size() != 0 || m_rem != 0) && i < 20 * W) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout", 64'(due_q.size()), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    start_pulse(16'h0000);
    wait_idle();

    start_pulse(16'h1F37);
    wait_idle();

    start_pulse(16'hFFFF);
    repeat (3) @(negedge clk);
    start_pulse(16'h0001);
    wait_idle();

    start_pulse(16'h1111);
    repeat (7) @(negedge clk);
    reset_pulse(1);
    start_pulse(16'h1111);
    wait_idle();

    start_pulse(16'h1F37);
    repeat (W) @(negedge clk);
    start_pulse(16'h0001);
    wait_idle();

    for (int it = 0; it < 30; it++) begin
      start_pulse(W'($urandom));
      for (int g = 0; g < $urandom_range(0, W + 6); g++) begin
        data_in = W'($urandom);
        start = ($urandom_range(0, 5) == 0);
        @(negedge clk);
      end
      start = 1'b0;
      if ($urandom_range(0, 7) == 0) reset_pulse($urandom_range(1, 2));
    end
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
